// File: rtl/sa_result_drain.sv
// Drain stage for the systolic array: captures per-row result vectors into a small
// vector FIFO and serializes the valid lanes onto a single valid/ready word stream.
module sa_result_drain #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DW-1:0]             routport [ROWS],
  input  logic [ROWS-1:0]           rvalidport,
  output logic                      outread,
  output logic [DW-1:0]             m_data,
  output logic [$clog2(ROWS)-1:0]   m_lane,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full
);

  localparam int unsigned LW = $clog2(ROWS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {IDLE, STREAM} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   data_mem [DEPTH][ROWS];
  logic [ROWS-1:0] mask_mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count_n;

  logic            capture, pop, load, advance, clear;
  logic [PW-1:0]   load_idx;
  logic [ROWS-1:0] head_mask, ld_mask, adv_rem;
  logic [LW-1:0]   ld_lane, adv_lane;
  logic            ld_last, adv_last;

  // Index of the lowest set bit; zero when none is set.
  function automatic logic [LW-1:0] lowest_set(input logic [ROWS-1:0] v);
    logic [LW-1:0] r;
    r = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (v[i]) r = LW'(i);
    end
    return r;
  endfunction

  // Mask of all lane positions strictly above the given lane.
  function automatic logic [ROWS-1:0] above(input logic [LW-1:0] lane);
    logic [ROWS-1:0] m;
    m = '0;
    for (int i = 0; i < ROWS; i++) begin
      m[i] = (i > int'(lane));
    end
    return m;
  endfunction

  // Capture decision uses the registered full flag, so a same-edge pop never admits a write.
  assign capture = rstn && (|rvalidport) && !full;
  assign outread = capture;
  assign count_n = count + CW'(capture) - CW'(pop);

  // Vector storage; occupancy is tracked by count, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      mask_mem[wptr] <= rvalidport;
      for (int i = 0; i < ROWS; i++) begin
        data_mem[wptr][i] <= routport[i];
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_idx = rptr;
    advance  = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load    = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (m_valid && m_ready) begin
          if (m_last) begin
            pop = 1'b1;
            if (count >= CW'(2)) begin
              load     = 1'b1;
              load_idx = rptr + PW'(1);
            end else begin
              clear   = 1'b1;
              state_n = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lane selection for a fresh entry and for stepping within the head entry.
  always_comb begin
    head_mask = mask_mem[rptr];
    ld_mask   = mask_mem[load_idx];
    ld_lane   = lowest_set(ld_mask);
    ld_last   = ~|(ld_mask & above(ld_lane));
    adv_rem   = head_mask & above(m_lane);
    adv_lane  = lowest_set(adv_rem);
    adv_last  = ~|(head_mask & above(adv_lane));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      full    <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_lane  <= '0;
      m_last  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      if (capture) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      if (load) begin
        m_valid <= 1'b1;
        m_lane  <= ld_lane;
        m_data  <= data_mem[load_idx][ld_lane];
        m_last  <= ld_last;
      end else if (advance) begin
        m_lane  <= adv_lane;
        m_data  <= data_mem[rptr][adv_lane];
        m_last  <= adv_last;
      end else if (clear) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: capture/ack timing, lane serialization order,
// FIFO full hold-off, stall stability, back-to-back vectors and mid-stream reset.
module tb_sa_result_drain;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(ROWS);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [LW-1:0] lane;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [DW-1:0]   routport [ROWS];
  logic [ROWS-1:0] rvalidport;
  logic            outread;
  logic [DW-1:0]   m_data;
  logic [LW-1:0]   m_lane;
  logic            m_last;
  logic            m_valid;
  logic            m_ready;
  logic [CW-1:0]   count;
  logic            full;

  int    tests = 0;
  int    fails = 0;
  int    beats_seen = 0;
  beat_t exp_q [$];
  logic  hold_v = 1'b0;
  beat_t hold_b;

  always #5 clk = ~clk;

  sa_result_drain #(.ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .routport   (routport),
    .rvalidport (rvalidport),
    .outread    (outread),
    .m_data     (m_data),
    .m_lane     (m_lane),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .count      (count),
    .full       (full)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input logic [ROWS-1:0] mask, input int base, input int step);
    for (int i = 0; i < ROWS; i++) routport[i] = DW'(base + step * i);
    rvalidport = mask;
  endtask

  // Expected beats: set lanes in ascending order, last flag on the highest set lane.
  task automatic expect_vec(input logic [ROWS-1:0] mask, input int base, input int step);
    int    hi;
    beat_t b;
    hi = -1;
    for (int i = 0; i < ROWS; i++) if (mask[i]) hi = i;
    for (int i = 0; i < ROWS; i++) begin
      if (mask[i]) begin
        b.lane = LW'(i);
        b.data = DW'(base + step * i);
        b.last = (i == hi);
        exp_q.push_back(b);
      end
    end
  endtask

  // One clock: stall-stability check, handshake scoreboard, then advance past the edge.
  task automatic cycle();
    beat_t b;
    if (hold_v) begin
      chk("stall_valid", DW'(m_valid), 1);
      chk("stall_lane",  DW'(m_lane), DW'(hold_b.lane));
      chk("stall_data",  m_data, hold_b.data);
      chk("stall_last",  DW'(m_last), DW'(hold_b.last));
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL extra_beat: observed lane %0d data %0h expected no beat", m_lane, m_data);
      end else begin
        b = exp_q.pop_front();
        chk("beat_lane", DW'(m_lane), DW'(b.lane));
        chk("beat_data", m_data, b.data);
        chk("beat_last", DW'(m_last), DW'(b.last));
      end
      beats_seen++;
    end
    hold_v = m_valid && !m_ready;
    hold_b.lane = m_lane;
    hold_b.data = m_data;
    hold_b.last = m_last;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      cycle();
      n++;
    end
    chk(tag, DW'(exp_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start;
    for (int i = 0; i < ROWS; i++) routport[i] = '0;
    rvalidport = '0;
    m_ready    = 1'b0;

    // Reset state; ack is suppressed while reset is held even with lanes valid
    repeat (2) @(posedge clk);
    #1;
    rvalidport = 8'hFF;
    #1;
    chk("rst_outread", DW'(outread), 0);
    chk("rst_count",   DW'(count), 0);
    chk("rst_full",    DW'(full), 0);
    chk("rst_valid",   DW'(m_valid), 0);
    chk("rst_data",    m_data, 0);
    rvalidport = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: full mask, data 3i+1
    m_ready = 1'b1;
    set_vec(8'hFF, 1, 3);
    expect_vec(8'hFF, 1, 3);
    #1;
    chk("t1_outread", DW'(outread), 1);
    cycle();
    chk("t1_count_after_capture", DW'(count), 1);
    chk("t1_valid_after_capture", DW'(m_valid), 0);
    rvalidport = '0;
    #1;
    chk("t1_outread_drop", DW'(outread), 0);
    cycle();
    chk("t1_first_valid", DW'(m_valid), 1);
    chk("t1_first_lane",  DW'(m_lane), 0);
    chk("t1_first_data",  m_data, 1);
    drain("t1_drain", 20);
    chk("t1_end_valid", DW'(m_valid), 0);
    chk("t1_end_count", DW'(count), 0);

    // Test 2: sparse mask, lanes 0,5,7 -> data 100,135,149
    set_vec(8'b1010_0001, 100, 7);
    expect_vec(8'b1010_0001, 100, 7);
    #1;
    chk("t2_outread", DW'(outread), 1);
    cycle();
    rvalidport = '0;
    cycle();
    chk("t2_first_data", m_data, 100);
    drain("t2_drain", 10);
    chk("t2_end_count", DW'(count), 0);

    // Test 3: fill FIFO with consumer stalled, fifth vector held until first pop
    m_ready = 1'b0;
    start = beats_seen;
    for (int k = 0; k < 4; k++) begin
      set_vec(8'hFF, 1000 * (k + 1), 1);
      expect_vec(8'hFF, 1000 * (k + 1), 1);
      #1;
      chk("t3_push_outread", DW'(outread), 1);
      cycle();
    end
    set_vec(8'hFF, 5000, 1);
    expect_vec(8'hFF, 5000, 1);
    #1;
    chk("t3_full",  DW'(full), 1);
    chk("t3_count", DW'(count), 4);
    chk("t3_hold_outread", DW'(outread), 0);
    cycle();
    chk("t3_hold_outread2", DW'(outread), 0);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_wait_outread", DW'(outread), 0);
      cycle();
    end
    chk("t3_after_pop_full",    DW'(full), 0);
    chk("t3_after_pop_count",   DW'(count), 3);
    chk("t3_after_pop_outread", DW'(outread), 1);
    cycle();
    rvalidport = '0;
    chk("t3_refill_count", DW'(count), 4);
    drain("t3_drain", 60);
    chk("t3_total_beats", DW'(beats_seen - start), 40);
    chk("t3_end_count", DW'(count), 0);

    // Test 4: ready toggles every cycle mid-vector
    set_vec(8'hFF, 200, 2);
    expect_vec(8'hFF, 200, 2);
    #1;
    chk("t4_outread", DW'(outread), 1);
    cycle();
    rvalidport = '0;
    cycle();
    start = beats_seen;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      m_ready = ~m_ready;
      cycle();
    end
    chk("t4_drain", DW'(exp_q.size()), 0);
    chk("t4_beats", DW'(beats_seen - start), 8);
    m_ready = 1'b1;
    cycle();
    chk("t4_end_valid", DW'(m_valid), 0);
    chk("t4_end_count", DW'(count), 0);

    // Test 5: two queued vectors stream without a bubble
    m_ready = 1'b0;
    set_vec(8'b0000_0110, 600, 3);
    expect_vec(8'b0000_0110, 600, 3);
    cycle();
    set_vec(8'b1001_0000, 700, 3);
    expect_vec(8'b1001_0000, 700, 3);
    cycle();
    rvalidport = '0;
    chk("t5_count", DW'(count), 2);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_bubble", DW'(m_valid), 1);
      cycle();
    end
    chk("t5_drain", DW'(exp_q.size()), 0);
    chk("t5_end_valid", DW'(m_valid), 0);

    // Test 6: reset asserted while beat 3 of 8 is presented
    set_vec(8'hFF, 300, 5);
    expect_vec(8'hFF, 300, 5);
    cycle();
    rvalidport = '0;
    cycle();
    cycle();
    cycle();
    chk("t6_beat3_lane", DW'(m_lane), 2);
    rstn = 1'b0;
    rvalidport = 8'hFF;
    #1;
    chk("t6_rst_valid",   DW'(m_valid), 0);
    chk("t6_rst_count",   DW'(count), 0);
    chk("t6_rst_data",    m_data, 0);
    chk("t6_rst_lane",    DW'(m_lane), 0);
    chk("t6_rst_last",    DW'(m_last), 0);
    chk("t6_rst_outread", DW'(outread), 0);
    rvalidport = '0;
    exp_q.delete();
    hold_v = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    set_vec(8'b0000_1101, 400, 1);
    expect_vec(8'b0000_1101, 400, 1);
    cycle();
    rvalidport = '0;
    cycle();
    chk("t6_restart_lane", DW'(m_lane), 0);
    chk("t6_restart_data", m_data, 400);
    drain("t6_drain", 10);
    chk("t6_end_count", DW'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
